operand_loader: RTL

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/alu_pkg.sv | 14 +
 rtl/operand_loader_if.sv | 29 ++
 rtl/operand_loader.sv | 65 ++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the operand loader: FSM state encodings and default widths.
package alu_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Bus between the operand producer/consumer and the loader.
// Handshake: a word moves on a rising edge where valid and ready are both 1;
// ready and valid never depend combinationally on the other side's signals.
interface operand_loader_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF,
  parameter int CNT_W = alu_pkg::CNT_W_DEF
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             op_valid;
  logic             op_ready;
  logic [CNT_W-1:0] ops_count;

  // Producer / downstream side
  modport master (
    output din, din_valid, op_ready,
    input  din_ready, a, b, sel, op_valid, ops_count
  );

  // Loader side
  modport slave (
    input  din, din_valid, op_ready,
    output din_ready, a, b, sel, op_valid, ops_count
  );
endinterface

// File: rtl/operand_loader.sv
// Collects A, B and an opcode bit from a narrow bus and presents them as one
// registered operation to a downstream ALU, counting consumed operations.
module operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  operand_loader_if.slave bus,
  output state_t  o_state
);

  state_t           r_state;
  state_t           w_next;
  logic             w_xfer;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;

  // Ready/valid are pure state decodes, so no input reaches an output combinationally.
  assign bus.din_ready = (r_state != S_HOLD);
  assign bus.op_valid  = (r_state == S_HOLD);
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.sel       = r_sel;
  assign bus.ops_count = r_cnt;
  assign o_state       = r_state;

  assign w_xfer = bus.din_valid && (r_state != S_HOLD);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_A:     if (w_xfer) w_next = S_B;
      S_B:     if (w_xfer) w_next = S_OP;
      S_OP:    if (w_xfer) w_next = S_HOLD;
      S_HOLD:  if (bus.op_ready) w_next = S_A;
      default: w_next = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_A;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sel <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_xfer && r_state == S_A)  r_a   <= bus.din;
      if (w_xfer && r_state == S_B)  r_b   <= bus.din;
      // Only the opcode LSB is meaningful; upper bits of the word are dropped.
      if (w_xfer && r_state == S_OP) r_sel <= bus.din[0];
      if (r_state == S_HOLD && bus.op_ready) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
